// File: rtl/ecdh_point_serializer.sv
// ecdh_point_serializer
// ---------------------
// Captures the (Qx, Qy) result point of the ECDH scalar-multiplication core
// on the rising edge of its valid and streams it out as BW_OUT-bit words on a
// valid/ready interface: Qx most-significant word first through Qx LSW, then
// Qy MSW through Qy LSW. A result that arrives while a frame is still draining
// is dropped and recorded in the sticky overrun flag.
//
// Optional feature: define SERIALIZER_HDR_EN to prepend one header beat
// {8'h04, zeros, 8'(2*WORDS)} (SEC1 uncompressed tag plus payload length).
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   in_valid  - result valid from scalar core (level, edge-detected)
//   Qx, Qy    - result coordinates, BW_GF bits each
//   in_ready  - high while idle, a new point will be captured
//   out_data  - current output word
//   out_valid - out_data is valid
//   out_ready - consumer accepts the word
//   out_last  - final payload beat of a point
//   busy      - high in any state other than idle
//   overrun   - sticky, a result arrived while not idle
module ecdh_point_serializer #(
  parameter int BW_GF  = 256,
  parameter int BW_OUT = 32,
  parameter int WORDS  = BW_GF / BW_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BW_GF-1:0]  Qx,
  input  logic [BW_GF-1:0]  Qy,
  output logic              in_ready,
  output logic [BW_OUT-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int SR_W = 2 * BW_GF;
`ifdef SERIALIZER_HDR_EN
  localparam int FRAME = 2 * WORDS + 1;
  localparam logic [BW_OUT-1:0] HDR_WORD =
    {8'h04, {(BW_OUT-16){1'b0}}, 8'(2 * WORDS)};
`else
  localparam int FRAME = 2 * WORDS;
`endif
  localparam int CW = $clog2(2 * WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX    = CW'(FRAME - 1);
  localparam logic [CW-1:0] PRELAST_IDX = CW'(FRAME - 2);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

`ifdef SERIALIZER_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_t;
`endif

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [SR_W-1:0]    shreg_r, shreg_s;
  logic               in_valid_d_r;
  logic [BW_OUT-1:0]  out_data_r, out_data_s;
  logic               out_valid_r, out_valid_s;
  logic               out_last_r, out_last_s;
  logic               busy_r, busy_s;
  logic               in_ready_r, in_ready_s;
  logic               overrun_r, overrun_s;
  logic               capture_s;

  // Rising edge of the core's valid: a held level yields a single capture.
  assign capture_s = in_valid & ~in_valid_d_r;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    shreg_s     = shreg_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    in_ready_s  = in_ready_r;
    // Any capture outside idle (including the final-beat cycle) is dropped.
    overrun_s   = overrun_r | (capture_s & (state_r != IDLE));

    case (state_r)
      IDLE: begin
        if (capture_s) begin
          shreg_s     = {Qx, Qy};
          cnt_s       = {CW{1'b0}};
          out_valid_s = 1'b1;
          out_last_s  = 1'b0;
          busy_s      = 1'b1;
          in_ready_s  = 1'b0;
`ifdef SERIALIZER_HDR_EN
          state_s     = HDR;
          out_data_s  = HDR_WORD;
`else
          state_s     = SEND;
          out_data_s  = Qx[BW_GF-1 -: BW_OUT];
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef SERIALIZER_HDR_EN
      HDR: begin
        // Header beat counts toward the frame but does not consume payload.
        if (out_ready) begin
          state_s    = SEND;
          cnt_s      = cnt_r + CNT_ONE;
          out_data_s = shreg_r[SR_W-1 -: BW_OUT];
          out_last_s = (cnt_r == PRELAST_IDX);
        end else begin
          state_s = HDR;
        end
      end
`endif
      SEND: begin
        if (out_ready) begin
          if (cnt_r == LAST_IDX) begin
            state_s     = IDLE;
            cnt_s       = {CW{1'b0}};
            shreg_s     = {SR_W{1'b0}};
            out_data_s  = {BW_OUT{1'b0}};
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            busy_s      = 1'b0;
            in_ready_s  = 1'b1;
          end else begin
            cnt_s      = cnt_r + CNT_ONE;
            shreg_s    = {shreg_r[SR_W-BW_OUT-1:0], {BW_OUT{1'b0}}};
            // Word that becomes the top of the register after this shift.
            out_data_s = shreg_r[SR_W-BW_OUT-1 -: BW_OUT];
            out_last_s = (cnt_r == PRELAST_IDX);
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = {CW{1'b0}};
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        busy_s      = 1'b0;
        in_ready_s  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      shreg_r      <= {SR_W{1'b0}};
      in_valid_d_r <= 1'b0;
      out_data_r   <= {BW_OUT{1'b0}};
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      in_ready_r   <= 1'b1;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shreg_r      <= shreg_s;
      in_valid_d_r <= in_valid;
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      out_last_r   <= out_last_s;
      busy_r       <= busy_s;
      in_ready_r   <= in_ready_s;
      overrun_r    <= overrun_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_ecdh_point_serializer.sv
// Testbench for ecdh_point_serializer: directed and randomized frames checked
// against a word-list model built by slicing the captured coordinates.
module tb_ecdh_point_serializer;

  localparam int BW_GF  = 256;
  localparam int BW_OUT = 32;
  localparam int WORDS  = BW_GF / BW_OUT;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [BW_GF-1:0]  Qx;
  logic [BW_GF-1:0]  Qy;
  logic              in_ready;
  logic [BW_OUT-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_data[$];
  logic        got_last[$];

  ecdh_point_serializer #(.BW_GF(BW_GF), .BW_OUT(BW_OUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Qx(Qx), .Qy(Qy),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Record the beat that the coming edge transfers, then advance one cycle.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: the frame is the optional header followed by the MSW-first
  // words of Qx and then of Qy.
  task automatic build_exp(input logic [BW_GF-1:0] qx, input logic [BW_GF-1:0] qy);
    exp_q.delete();
`ifdef SERIALIZER_HDR_EN
    exp_q.push_back(32'h0400_0010);
`endif
    for (int i = WORDS - 1; i >= 0; i--) exp_q.push_back(qx[32*i +: 32]);
    for (int i = WORDS - 1; i >= 0; i--) exp_q.push_back(qy[32*i +: 32]);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at beat index 2.
  // hold: keep in_valid high through the frame. ovr_idx: inject an all-ones
  // capture while beat ovr_idx is presented (-1 = none).
  task automatic run_frame(input logic [BW_GF-1:0] qx, input logic [BW_GF-1:0] qy,
                           input int rmode, input int hold, input int ovr_idx);
    int stall = 0;
    int inj = 0;
    bit done = 1'b0;
    got_data.delete();
    got_last.delete();
    build_exp(qx, qy);
    Qx = qx;
    Qy = qy;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    chk("in_ready_in_frame", {31'd0, in_ready}, 32'd0);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (hold == 0) in_valid = 1'b0;
      if (ovr_idx >= 0 && inj == 0 && got_data.size() == ovr_idx) begin
        Qx = '1;
        Qy = '1;
        in_valid = 1'b1;
        inj = 1;
      end
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (got_data.size() == 2 && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid === 1'b1) begin
        if (got_data.size() < exp_q.size()) begin
          chk("beat_data", out_data, exp_q[got_data.size()]);
          chk("beat_last", {31'd0, out_last},
              (got_data.size() == exp_q.size() - 1) ? 32'd1 : 32'd0);
        end else begin
          chk("extra_beat", got_data.size(), exp_q.size() - 1);
        end
      end
      tick();
      if (got_last.size() > 0 && got_last[got_last.size()-1] === 1'b1) done = 1'b1;
    end
    chk("frame_done", {31'd0, done}, 32'd1);
    chk("beat_count", got_data.size(), exp_q.size());
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      chk("frame_word", got_data[i], exp_q[i]);
    chk("after_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_busy", {31'd0, busy}, 32'd0);
    if (hold == 0) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  logic [BW_GF-1:0] ax, by, rx, ry;
  int nbeats;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Qx = '0;
    Qy = '0;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < WORDS; i++) begin
      ax[32*i +: 32] = 32'hA000_0000 + 32'(i);
      by[32*i +: 32] = 32'hB000_0000 + 32'(i);
    end

    // Basic frame, always ready.
    run_frame(ax, by, 0, 0, -1);
    // Backpressure stall on the third beat.
    run_frame(ax, by, 2, 0, -1);
    // Randomized points and random backpressure.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < WORDS; i++) begin
        rx[32*i +: 32] = $urandom;
        ry[32*i +: 32] = $urandom;
      end
      run_frame(rx, ry, 1, 0, -1);
    end
    chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Held level: one frame only, then nothing while the level stays high.
    run_frame(ax, by, 0, 1, -1);
    nbeats = got_data.size();
    for (int c = 0; c < 23; c++) tick();
    chk("hold_no_second_frame", got_data.size(), nbeats);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_overrun", {31'd0, overrun}, 32'd0);
    in_valid = 1'b0;
    tick();

    // Overrun: second edge at beat 6 with all-ones data is dropped.
    run_frame(ax, by, 0, 0, 6);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    run_frame(by, ax, 1, 0, -1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-frame after four beats.
    got_data.delete();
    got_last.delete();
    Qx = ax;
    Qy = by;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 50 && got_data.size() < 4; c++) tick();
    chk("pre_reset_beats", got_data.size(), 32'd4);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    nbeats = got_data.size();
    for (int c = 0; c < 3; c++) tick();
    chk("midrst_no_beats", got_data.size(), nbeats);
    for (int i = 0; i < WORDS; i++) begin
      rx[32*i +: 32] = $urandom;
      ry[32*i +: 32] = $urandom;
    end
    run_frame(rx, ry, 0, 0, -1);
    chk("post_rst_overrun", {31'd0, overrun}, 32'd0);

    // Capture coinciding with the final beat transfer still counts as overrun.
`ifdef SERIALIZER_HDR_EN
    run_frame(ax, by, 0, 0, 2 * WORDS);
`else
    run_frame(ax, by, 0, 0, 2 * WORDS - 1);
`endif
    chk("overrun_last_beat", {31'd0, overrun}, 32'd1);
    for (int c = 0; c < 3; c++) tick();
    chk("last_beat_drop_idle", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecdh_point_serializer.md
Name: ecdh_point_serializer

Overview:
- Downstream stage of the ECDH scalar-multiplication core. Captures the 256-bit result point (Qx, Qy) when the core asserts its valid.
- Streams the point out as fixed-width words over a valid/ready interface to the host/bus side.
- Decouples the wide core result from a narrow output bus with full backpressure support, and flags results that arrive while a previous point is still draining.

Parameters:
- BW_GF, 256, coordinate width in bits; must be a multiple of BW_OUT.
- BW_OUT, 32, output word width in bits.
- WORDS, BW_GF/BW_OUT (8), derived; beats per coordinate.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- in_valid  input  1  result-valid from scalar core; level, may stay high several cycles.
- Qx  input  BW_GF  result X coordinate.
- Qy  input  BW_GF  result Y coordinate.
- in_ready  output  1  high while IDLE (a new point will be captured).
- out_data  output  BW_OUT  current output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- out_last  output  1  marks the final beat of a point.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky; a result arrived while not IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, beat counter=0, shift register=0, in_valid_d=0. Outputs: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, in_ready=1. Reset mid-frame abandons the frame with no further beats.
- Capture event = in_valid & ~in_valid_d, i.e. the rising edge; in_valid_d is a registered copy. A level held high yields exactly one capture. A high in_valid in the first cycle after reset counts as an edge.
- IDLE + capture: load {Qx,Qy} into a 2*BW_GF shift register and go to SEND. out_valid=1 on the next cycle (latency 1 clock from edge to first beat).
- SEND:
  - out_data = shift register top BW_OUT bits.
  - A beat transfers when out_valid & out_ready.
  - On transfer: shift left by BW_OUT and increment the beat counter.
  - Word order: Qx MSW (Qx[255:224]) first through Qx LSW, then Qy MSW through Qy LSW. 2*WORDS beats total.
- out_last=1 only while the final beat is presented. Transfer of the last beat returns to IDLE; out_valid=0 next cycle.
- Backpressure: while out_valid & ~out_ready, out_data, out_last and state are held unchanged. No beat is skipped or duplicated.
- Overrun: a capture event while state != IDLE, including the cycle the last beat transfers, sets overrun=1 and the new point is dropped. The current frame is unaffected. overrun clears only on rst.
- Counters: beat counter width is clog2(2*WORDS+1); it never exceeds the frame length.
- States: IDLE, (HDR when the optional feature is enabled), SEND.

Optional Feature:
- Macro SERIALIZER_HDR_EN.
- Defined:
  - IDLE+capture goes to HDR; one header beat precedes the payload.
  - Header beat: out_data = {8'h04 (SEC1 uncompressed tag), zeros, 8'd(2*WORDS)}, which is 32'h0400_0010 at defaults.
  - Header transfer goes to SEND. Frame = 2*WORDS+1 beats; out_last still marks the final payload beat.
  - First-beat latency is unchanged (1 clock); the header obeys the same backpressure rules.
- Undefined: no HDR state; frame = 2*WORDS beats starting with the Qx MSW.

Test Plan:
- Basic frame, out_ready=1: Qx words A0000007..A0000000 (MSW..LSW), Qy words B0000007..B0000000, in_valid pulse → out_valid one cycle later, then 16 consecutive beats A0000007..A0000000,B0000007..B0000000. out_last only on B0000000. in_ready=0 for 16 cycles, then 1.
- Backpressure: same point, out_ready=0 during beats 3-5 → out_data held at A0000005 for all stalled cycles. Totals are exactly 16 beats in order.
- Held level: in_valid high for 40 cycles → exactly one frame, overrun=0.
- Overrun: second in_valid rising edge at beat 6 with Qx=Qy=all-ones → overrun=1 sticky. Frame continues with the original data and no all-ones beat appears. overrun clears only after rst.
- Reset mid-frame: rst at beat 4 → next cycle out_valid=0, busy=0, in_ready=1. A new capture afterwards restarts from its Qx MSW.
- SERIALIZER_HDR_EN defined: basic frame → first beat 0400_0010, then the 16 payload beats. 17 beats total, out_last on B0000000.
